logo_motion: RTL
================

# logo_motion

Frame-rate motion controller for the bouncing-logo screensaver. Once per video frame it advances the logo's top-left position and bounces the logo off the visible screen edges. On every bounce it steps the colour index that feeds the downstream palette lookup. Its outputs are the logo origin consumed by the pixel/logo renderer and the 3-bit `color_index` consumed by the palette stage.

## Interface

Parameters:
- `H_ACTIVE`, default 640: visible width in pixels.
- `V_ACTIVE`, default 480: visible height in pixels.
- `LOGO_W`, default 64: logo width in pixels.
- `LOGO_H`, default 64: logo height in pixels.
- `START_X`, default 100: logo X after reset.
- `START_Y`, default 50: logo Y after reset.
- `STEP`, default 1: pixels moved per frame per axis, 1..15.
- `NUM_COLORS`, default 7: colour indices cycled, 0..NUM_COLORS-1. Index 7 is reserved for white/foreground and is never produced.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `frame_tick` in 1: one-cycle pulse, asserted once per frame inside vertical blanking.
- `pause` in 1: while high, ticks are ignored (no motion, no colour change).
- `logo_x` out 10: logo left edge, 0..H_ACTIVE-LOGO_W.
- `logo_y` out 10: logo top edge, 0..V_ACTIVE-LOGO_H.
- `color_index` out 3: current logo colour, to the palette.
- `bounce` out 1: one-cycle pulse when ≥1 edge was hit on the last update.
- `corner` out 1: one-cycle pulse when both axes hit an edge on the same update.

## Operation

- Constants: X_MAX = H_ACTIVE-LOGO_W (576), Y_MAX = V_ACTIVE-LOGO_H (416).
- Per axis, state is position p plus direction d (0 = increasing, 1 = decreasing). Reset: d = 0 on both axes.
- An update happens on any cycle with `frame_tick`=1 and `pause`=0.
- Per-axis update, computed in 11-bit unsigned arithmetic so no intermediate wraps:
  - d=0, p+STEP ≥ MAX: p ← MAX, d ← 1, axis hit.
  - d=0, otherwise: p ← p+STEP.
  - d=1, p ≤ STEP: p ← 0, d ← 0, axis hit.
  - d=1, otherwise: p ← p−STEP.
- Landing exactly on an edge counts as a hit and flips direction in the same update. The next update moves away from that edge.
- Colour index:
  - If either axis hit, `color_index` ← (idx+1) mod NUM_COLORS.
  - A corner (both axes hit) advances the index exactly once, not twice.
  - Wrap is NUM_COLORS-1 → 0.
- `bounce` pulses on any hit. `corner` pulses when both axes hit. Both are 0 on every other cycle.
- `frame_tick` high for more than one cycle is a protocol violation, but each high cycle is treated as an independent tick.
- `pause` and `frame_tick` together: the tick is dropped, not deferred.
- Reset has priority over a coincident tick.
- Reset values:
  - `logo_x` = START_X, `logo_y` = START_Y.
  - `color_index` = 0.
  - `bounce` = 0, `corner` = 0.
  - Directions = 0.
- Out-of-range START values are clamped to MAX at elaboration.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Latency: a tick sampled at edge N produces new `logo_x`, `logo_y`, `color_index`, `bounce` and `corner` after edge N. Pulses are high for exactly that one cycle.
- Outputs are stable for the whole following frame. Because ticks arrive in blanking, the renderer never sees a mid-frame change.
- Reset takes effect on the first rising edge with `rst_n`=0, including in the middle of a frame or a pulse.

## Structure

- Shared package `screensaver_pkg`:
  - screen constants H_ACTIVE, V_ACTIVE;
  - logo constants LOGO_W, LOGO_H;
  - NUM_COLORS and the colour-index width (3);
  - the reserved index 7.
- Sub-module `bounce_axis`, instantiated twice (X, Y):
  - parameters MAX, START, STEP;
  - inputs `clk`, `rst_n`, `step_en`;
  - outputs `pos` (10 bits), `hit`.
- The top level holds `color_index`, the hit/corner combine logic, and the pulse registers.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles with `frame_tick` toggling → `logo_x`=100, `logo_y`=50, `color_index`=0, `bounce`=0, `corner`=0.
- Right-edge bounce (STEP=1), from x=575 moving right:
  - tick → x=576, `bounce`=1 for one cycle, `color_index` 0→1;
  - next tick → x=575, no bounce.
- Clamp (STEP=2), from x=575 moving right: tick → x=576 (not 577), direction flips. Then from x=1 moving left: tick → x=0 with a hit.
- Corner, from x=575 right and y=415 down: one tick →
  - x=576, y=416;
  - `bounce`=1, `corner`=1;
  - `color_index` advances by exactly 1.
- Colour wrap and pause:
  - `color_index`=6, bounce → 0;
  - `pause`=1 with 5 ticks → position and colour unchanged;
  - release `pause`, next tick moves by STEP.
- Reset mid-operation: assert `rst_n`=0 in the same cycle as a bouncing tick → reset values appear, and no `bounce` pulse is emitted.

Source files
------------

// File: rtl/screensaver_pkg.sv
// rtl/screensaver_pkg.sv - shared screen, logo and palette constants for the screensaver
package screensaver_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int LOGO_W     = 64;
    localparam int LOGO_H     = 64;
    localparam int NUM_COLORS = 7;
    localparam int CIDX_W     = 3;

    localparam logic [CIDX_W-1:0] COLOR_RESERVED = 3'd7;

    // Reserved white index is never produced; landing on it or past the last colour wraps to 0.
    function automatic logic [CIDX_W-1:0] next_color(input logic [CIDX_W-1:0] idx, input int n);
        if ((idx >= CIDX_W'(n - 1)) || (idx == COLOR_RESERVED)) begin
            return '0;
        end
        return idx + CIDX_W'(1);
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// rtl/bounce_axis.sv - one axis of logo motion: position, direction and edge-hit detect
module bounce_axis #(
    parameter int MAX   = 576,
    parameter int START = 0,
    parameter int STEP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    output logic [9:0] pos,
    output logic       hit
);
    import screensaver_pkg::*;

    localparam int          START_C = (START > MAX) ? MAX : START;
    localparam logic [10:0] MAX_L   = 11'(MAX);
    localparam logic [10:0] STEP_L  = 11'(STEP);
    localparam logic [10:0] START_L = 11'(START_C);

    logic [9:0]  r_pos;
    logic        r_dir;
    logic [10:0] w_sum;
    logic [9:0]  w_next_pos;
    logic        w_next_dir;
    logic        w_hit;

    // 11-bit sum so p+STEP near MAX cannot wrap before the compare.
    assign w_sum = {1'b0, r_pos} + STEP_L;

    always_comb begin
        w_next_pos = r_pos;
        w_next_dir = r_dir;
        w_hit      = 1'b0;
        if (step_en) begin
            if (!r_dir) begin
                if (w_sum >= MAX_L) begin
                    w_next_pos = MAX_L[9:0];
                    w_next_dir = 1'b1;
                    w_hit      = 1'b1;
                end else begin
                    w_next_pos = w_sum[9:0];
                end
            end else begin
                if ({1'b0, r_pos} <= STEP_L) begin
                    w_next_pos = '0;
                    w_next_dir = 1'b0;
                    w_hit      = 1'b1;
                end else begin
                    w_next_pos = r_pos - STEP_L[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos <= START_L[9:0];
            r_dir <= 1'b0;
        end else begin
            r_pos <= w_next_pos;
            r_dir <= w_next_dir;
        end
    end

    assign pos = r_pos;
    assign hit = w_hit;

endmodule

// File: rtl/logo_motion.sv
// rtl/logo_motion.sv - per-frame bouncing-logo position and colour controller
module logo_motion #(
    parameter int H_ACTIVE   = screensaver_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = screensaver_pkg::V_ACTIVE,
    parameter int LOGO_W     = screensaver_pkg::LOGO_W,
    parameter int LOGO_H     = screensaver_pkg::LOGO_H,
    parameter int START_X    = 100,
    parameter int START_Y    = 50,
    parameter int STEP       = 1,
    parameter int NUM_COLORS = screensaver_pkg::NUM_COLORS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       pause,
    output logic [9:0] logo_x,
    output logic [9:0] logo_y,
    output logic [2:0] color_index,
    output logic       bounce,
    output logic       corner
);
    import screensaver_pkg::*;

    localparam int X_MAX = H_ACTIVE - LOGO_W;
    localparam int Y_MAX = V_ACTIVE - LOGO_H;

    logic                w_update;
    logic                w_hit_x;
    logic                w_hit_y;
    logic [CIDX_W-1:0]   r_color;
    logic                r_bounce;
    logic                r_corner;

    // A paused tick is dropped outright rather than held for later.
    assign w_update = frame_tick & ~pause;

    bounce_axis #(.MAX(X_MAX), .START(START_X), .STEP(STEP)) u_axis_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (w_update),
        .pos     (logo_x),
        .hit     (w_hit_x)
    );

    bounce_axis #(.MAX(Y_MAX), .START(START_Y), .STEP(STEP)) u_axis_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (w_update),
        .pos     (logo_y),
        .hit     (w_hit_y)
    );

    // A corner is a single bounce event, so the colour advances once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_color  <= '0;
            r_bounce <= 1'b0;
            r_corner <= 1'b0;
        end else begin
            r_bounce <= w_hit_x | w_hit_y;
            r_corner <= w_hit_x & w_hit_y;
            if (w_hit_x | w_hit_y) begin
                r_color <= next_color(r_color, NUM_COLORS);
            end
        end
    end

    assign color_index = r_color;
    assign bounce      = r_bounce;
    assign corner      = r_corner;

endmodule
